// File: rtl/mem_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stream_reader
//  Purpose  : Reads a burst of consecutive words from a vector memory with a
//             combinational read port and presents them as a valid/ready
//             stream, one word per cycle while the consumer is ready.
//
//  Ports    :
//    clk              in   1     clock, rising-edge active
//    reset            in   1     synchronous active-high reset
//    start            in   1     burst request, only honoured in IDLE
//    base_address     in   AW    first word address of the burst
//    length           in   AW    number of words in the burst
//    mem_read_address out  AW    registered read address to the memory
//    mem_read_data    in   W     combinational read data for that address
//    out_data         out  W     registered stream data
//    out_valid        out  1     out_data holds an unconsumed word
//    out_ready        in   1     consumer accepts the current word
//    busy             out  1     burst in progress (STREAM or DONE)
//    finish           out  1     one-cycle end-of-burst pulse
//
//  Revision : 1.0  initial release
// ============================================================================
module mem_stream_reader #(
  parameter int element_width          = 64,
  parameter int memories_address_width = 20,
  parameter int no_of_units            = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [memories_address_width-1:0]         base_address,
  input  logic [memories_address_width-1:0]         length,
  output logic [memories_address_width-1:0]         mem_read_address,
  input  logic [no_of_units*element_width-1:0]      mem_read_data,
  output logic [no_of_units*element_width-1:0]      out_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      busy,
  output logic                                      finish
);

  localparam int aw = memories_address_width;

  localparam logic [1:0] st_idle   = 2'd0;
  localparam logic [1:0] st_stream = 2'd1;
  localparam logic [1:0] st_done   = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [aw-1:0] length_q;   // burst length held for the whole burst
  logic [aw-1:0] issued;     // words loaded into the output register so far
  logic          capture;
  logic          load;
  logic          transfer;

  // --------------------------------------------------------------------------
  // Control qualifiers
  // --------------------------------------------------------------------------
  always_comb begin
    capture  = (state == st_idle) && start;
    transfer = (state == st_stream) && out_valid && out_ready;
    // The output register may be refilled when empty or when it is being
    // drained in this same cycle, which gives one word per cycle.
    load     = (state == st_stream) && (issued < length_q) &&
               (!out_valid || out_ready);
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= st_idle;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      st_idle: begin
        if (start) begin
          state_next = (length == '0) ? st_done : st_stream;
        end
      end
      st_stream: begin
        // Every word has been loaded once issued reaches length, so a
        // transfer at that point is the final word leaving the register.
        if (transfer && (issued == length_q)) begin
          state_next = st_done;
        end
      end
      st_done: begin
        state_next = st_idle;
      end
      default: begin
        state_next = st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy   = (state == st_stream) || (state == st_done);
    finish = (state == st_done);
  end

  // --------------------------------------------------------------------------
  // Datapath: address generator, issue counter and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_address <= '0;
      length_q         <= '0;
      issued           <= '0;
      out_data         <= '0;
      out_valid        <= 1'b0;
    end else begin
      if (capture) begin
        length_q <= length;
        issued   <= '0;
        // A zero-length burst never reads, so the address is left alone.
        if (length != '0) begin
          mem_read_address <= base_address;
        end
      end

      if (load) begin
        out_data         <= mem_read_data;
        out_valid        <= 1'b1;
        mem_read_address <= mem_read_address + 1'b1;  // wraps modulo 2^aw
        issued           <= issued + 1'b1;
      end else if (transfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stream_reader
//  Purpose  : Self-checking bench for mem_stream_reader. A memory model
//             returns {salt, address} for every read; each burst is checked
//             against an expected queue of ascending wrapped addresses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stream_reader;

  localparam int EW = 64;
  localparam int AW = 20;
  localparam int NU = 8;
  localparam int W  = EW * NU;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_address;
  logic [AW-1:0] length;
  logic [AW-1:0] mem_read_address;
  logic [W-1:0]  mem_read_data;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          finish;

  logic [W-AW-1:0] salt;

  int checks   = 0;
  int failures = 0;

  mem_stream_reader #(
    .element_width          (EW),
    .memories_address_width (AW),
    .no_of_units            (NU)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_address     (base_address),
    .length           (length),
    .mem_read_address (mem_read_address),
    .mem_read_data    (mem_read_data),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .finish           (finish)
  );

  // Memory model: combinational read, content derived from the address.
  assign mem_read_data = {salt, mem_read_address};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    int            mode;      // 0: ready always 1, 1: ready 1,0,0 pattern, 2: random
    bit            poke;      // pulse start with garbage mid-burst
    int            exp_fin;   // expected finish cycle index, -1 = not checked
  } vec_t;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, W'(out_valid), '0);
    chk({tag, "_out_data"},  out_data, '0);
    chk({tag, "_address"},   W'(mem_read_address), '0);
    chk({tag, "_busy"},      W'(busy), '0);
    chk({tag, "_finish"},    W'(finish), '0);
  endtask

  // Runs one burst and checks order, content, stalls, finish timing.
  // Cycle index c = 0 is the first cycle after the accepting edge.
  task automatic run_burst(input logic [AW-1:0] b, input logic [AW-1:0] n,
                           input int mode, input bit poke, input int exp_fin);
    logic [AW-1:0] exp_q[$];
    int            fin_cycle;
    int            fin_count;
    int            ntx;
    int            budget;
    bit            stall;
    bit            r;
    logic [W-1:0]  pdata;
    logic [AW-1:0] paddr;

    for (int i = 0; i < int'(n); i++) exp_q.push_back(b + AW'(i));
    fin_cycle = -1;
    fin_count = 0;
    ntx       = 0;
    stall     = 1'b0;
    pdata     = '0;
    paddr     = '0;
    budget    = 4 * int'(n) + 10;

    start        = 1'b1;
    base_address = b;
    length       = n;
    out_ready    = 1'b0;
    tick();
    start = 1'b0;
    chk("accept_busy", W'(busy), W'(1'b1));
    chk("accept_valid", W'(out_valid), '0);

    for (int c = 0; c < budget; c++) begin
      if (fin_count > 0 && !finish) begin
        chk("idle_after_done_busy", W'(busy), '0);
        break;
      end
      if (finish) begin
        fin_count++;
        if (fin_count == 1) fin_cycle = c;
        chk("finish_valid_low", W'(out_valid), '0);
        chk("finish_word_count", W'(ntx), W'(n));
      end
      if (c == 1 && n != '0) chk("first_valid", W'(out_valid), W'(1'b1));
      if (stall) begin
        chk("stall_valid", W'(out_valid), W'(1'b1));
        chk("stall_data", out_data, pdata);
        chk("stall_address", W'(mem_read_address), W'(paddr));
      end

      case (mode)
        0:       r = 1'b1;
        1:       r = ((c % 3) == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready    = r;
      base_address = AW'($urandom);
      length       = AW'($urandom);
      start        = poke && (c == 2);

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", W'(1'b1), '0);
        end else begin
          chk("stream_data", out_data, {salt, exp_q.pop_front()});
        end
        ntx++;
      end
      stall = out_valid && !out_ready;
      pdata = out_data;
      paddr = mem_read_address;
      tick();
    end

    start     = 1'b0;
    out_ready = 1'b0;
    chk("finish_pulse_count", W'(fin_count), W'(1));
    if (exp_fin >= 0) chk("finish_cycle", W'(fin_cycle), W'(exp_fin));
    chk("words_delivered", W'(ntx), W'(n));
  endtask

  vec_t vecs[6];

  initial begin
    int ntx;

    vecs[0] = '{base: 20'd5,       len: 20'd4, mode: 0, poke: 1'b0, exp_fin: 5};
    vecs[1] = '{base: 20'd5,       len: 20'd4, mode: 1, poke: 1'b0, exp_fin: -1};
    vecs[2] = '{base: 20'd0,       len: 20'd0, mode: 0, poke: 1'b0, exp_fin: 0};
    vecs[3] = '{base: 20'hFFFFE,   len: 20'd4, mode: 0, poke: 1'b0, exp_fin: 5};
    vecs[4] = '{base: 20'd100,     len: 20'd6, mode: 0, poke: 1'b1, exp_fin: 7};
    vecs[5] = '{base: 20'd0,       len: 20'd1, mode: 0, poke: 1'b0, exp_fin: 2};

    salt         = '0;
    reset        = 1'b1;
    start        = 1'b0;
    base_address = '0;
    length       = '0;
    out_ready    = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      run_burst(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].poke, vecs[i].exp_fin);
    end

    // Reset after the second of six transfers
    salt         = '0;
    start        = 1'b1;
    base_address = 20'd10;
    length       = 20'd6;
    out_ready    = 1'b1;
    tick();
    start = 1'b0;
    ntx   = 0;
    for (int c = 0; c < 20 && ntx < 2; c++) begin
      if (out_valid && out_ready) ntx++;
      tick();
    end
    chk("pre_reset_transfers", W'(ntx), W'(2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("midburst_reset");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_reset_finish", W'(finish), '0);
      chk("post_reset_valid", W'(out_valid), '0);
    end
    run_burst(20'd0, 20'd1, 0, 1'b0, 2);

    // Randomised bursts
    for (int t = 0; t < 25; t++) begin
      logic [AW-1:0] b;
      logic [AW-1:0] n;
      for (int k = 0; k < 16; k++) salt = (salt << 32) | (W-AW)'($urandom);
      if ($urandom_range(0, 3) == 0) b = 20'hFFFFF - AW'($urandom_range(0, 5));
      else                           b = AW'($urandom);
      n = AW'($urandom_range(0, 12));
      run_burst(b, n, 2, 1'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
